pec_row_seq: RTL and testbench

- Row sequencer directly upstream of the CNVROW convolution-row stage.
- Per output column of a row:
  - pulls one activation block and three weight blocks from the PE buffer through a valid/ready handshake;
  - holds them stable on the MAC operand bus and fires a start pulse to the three MACAW units;
  - waits until all three finish flags have arrived;
  - issues the accumulate/shift pulse to CNVROW.
- After LENROW columns it issues the row-finish pulse and returns to idle.

---
 rtl/pec_row_seq.sv | 186 ++++++++++++++++++
 tb/tb_pec_row_seq.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pec_row_seq.sv
// Row sequencer feeding CNVROW: fetches one activation + three weight blocks per column,
// starts the three MACs, joins their finish pulses, then pulses accumulate; row-finish after LENROW columns.
module pec_row_seq #(
  parameter int DATA_WIDTH  = 8,
  parameter int BLOCK_DEPTH = 32,
  parameter int LENROW      = 16,
  localparam int BW    = DATA_WIDTH*BLOCK_DEPTH,
  localparam int COL_W = (LENROW > 1) ? $clog2(LENROW) : 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   CTRL_RowSta,
  input  logic                   CTRL_Abort,
  output logic                   CTRL_RowRdy,
  output logic                   CTRL_RowDone,
  output logic                   CTRL_Err,
  input  logic                   BUF_Vld,
  output logic                   BUF_Rdy,
  input  logic [BLOCK_DEPTH-1:0] BUF_FlgAct,
  input  logic [BW-1:0]          BUF_Act,
  input  logic [BLOCK_DEPTH-1:0] BUF_FlgWei0,
  input  logic [BLOCK_DEPTH-1:0] BUF_FlgWei1,
  input  logic [BLOCK_DEPTH-1:0] BUF_FlgWei2,
  input  logic [BW-1:0]          BUF_Wei0,
  input  logic [BW-1:0]          BUF_Wei1,
  input  logic [BW-1:0]          BUF_Wei2,
  output logic [BLOCK_DEPTH-1:0] PECMAC_FlgAct,
  output logic [BW-1:0]          PECMAC_Act,
  output logic [BLOCK_DEPTH-1:0] PECMAC_FlgWei0,
  output logic [BLOCK_DEPTH-1:0] PECMAC_FlgWei1,
  output logic [BLOCK_DEPTH-1:0] PECMAC_FlgWei2,
  output logic [BW-1:0]          PECMAC_Wei0,
  output logic [BW-1:0]          PECMAC_Wei1,
  output logic [BW-1:0]          PECMAC_Wei2,
  output logic                   PECMAC_Sta,
  input  logic                   MACPEC_Fnh0,
  input  logic                   MACPEC_Fnh1,
  input  logic                   MACPEC_Fnh2,
  output logic                   PECCNV_PlsAcc,
  output logic                   PECCNV_FnhRow,
  output logic [COL_W-1:0]       Col
);

  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_START, S_WAIT, S_ACC, S_DONE} state_t;

  typedef struct packed {
    logic [BLOCK_DEPTH-1:0] flg_act;
    logic [BW-1:0]          act;
    logic [BLOCK_DEPTH-1:0] flg_wei0;
    logic [BLOCK_DEPTH-1:0] flg_wei1;
    logic [BLOCK_DEPTH-1:0] flg_wei2;
    logic [BW-1:0]          wei0;
    logic [BW-1:0]          wei1;
    logic [BW-1:0]          wei2;
  } ops_t;

  localparam logic [COL_W-1:0] COL_LAST = COL_W'(LENROW-1);

  state_t           state_q, state_d;
  logic [COL_W-1:0] col_q, col_d;
  logic [2:0]       fdone_q, fdone_d;
  logic             err_q, err_d;
  ops_t             ops_q, ops_d;
  logic             row_rdy_q, row_rdy_d;
  logic             buf_rdy_q, buf_rdy_d;
  logic             sta_q, sta_d;
  logic             pls_acc_q, pls_acc_d;
  logic             fnh_row_q, fnh_row_d;
  logic [2:0]       fnh;
  logic             hs;

  assign fnh = {MACPEC_Fnh2, MACPEC_Fnh1, MACPEC_Fnh0};
  assign hs  = (state_q == S_FETCH) && BUF_Vld && buf_rdy_q;

  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    fdone_d = fdone_q;
    ops_d   = ops_q;
    err_d   = err_q;

    // A finish pulse is legal only in WAIT, and only once per MAC per column.
    if (state_q != S_WAIT) err_d = err_q | (|fnh);
    else                   err_d = err_q | (|(fnh & fdone_q));

    case (state_q)
      S_IDLE: begin
        if (CTRL_RowSta) begin
          state_d = S_FETCH;
          col_d   = '0;
        end
      end
      S_FETCH: begin
        if (hs && !CTRL_Abort) begin
          ops_d.flg_act  = BUF_FlgAct;
          ops_d.act      = BUF_Act;
          ops_d.flg_wei0 = BUF_FlgWei0;
          ops_d.flg_wei1 = BUF_FlgWei1;
          ops_d.flg_wei2 = BUF_FlgWei2;
          ops_d.wei0     = BUF_Wei0;
          ops_d.wei1     = BUF_Wei1;
          ops_d.wei2     = BUF_Wei2;
          state_d        = S_START;
        end
      end
      S_START: begin
        fdone_d = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        fdone_d = fdone_q | fnh;
        if (&(fdone_q | fnh)) state_d = S_ACC;
      end
      S_ACC: begin
        if (col_q == COL_LAST) begin
          state_d = S_DONE;
        end else begin
          col_d   = col_q + COL_W'(1);
          state_d = S_FETCH;
        end
      end
      S_DONE: begin
        col_d   = '0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (CTRL_Abort) begin
      state_d = S_IDLE;
      col_d   = '0;
      fdone_d = '0;
    end

    // Outputs are registered from the next state so they line up with state_q.
    row_rdy_d = (state_d == S_IDLE);
    buf_rdy_d = (state_d == S_FETCH);
    sta_d     = (state_d == S_START);
    pls_acc_d = (state_d == S_ACC);
    fnh_row_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      col_q     <= '0;
      fdone_q   <= '0;
      err_q     <= 1'b0;
      ops_q     <= '0;
      row_rdy_q <= 1'b1;
      buf_rdy_q <= 1'b0;
      sta_q     <= 1'b0;
      pls_acc_q <= 1'b0;
      fnh_row_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      col_q     <= col_d;
      fdone_q   <= fdone_d;
      err_q     <= err_d;
      ops_q     <= ops_d;
      row_rdy_q <= row_rdy_d;
      buf_rdy_q <= buf_rdy_d;
      sta_q     <= sta_d;
      pls_acc_q <= pls_acc_d;
      fnh_row_q <= fnh_row_d;
    end
  end

  assign CTRL_RowRdy    = row_rdy_q;
  assign CTRL_RowDone   = fnh_row_q;
  assign CTRL_Err       = err_q;
  assign BUF_Rdy        = buf_rdy_q;
  assign PECMAC_Sta     = sta_q;
  assign PECCNV_PlsAcc  = pls_acc_q;
  assign PECCNV_FnhRow  = fnh_row_q;
  assign Col            = col_q;
  assign PECMAC_FlgAct  = ops_q.flg_act;
  assign PECMAC_Act     = ops_q.act;
  assign PECMAC_FlgWei0 = ops_q.flg_wei0;
  assign PECMAC_FlgWei1 = ops_q.flg_wei1;
  assign PECMAC_FlgWei2 = ops_q.flg_wei2;
  assign PECMAC_Wei0    = ops_q.wei0;
  assign PECMAC_Wei1    = ops_q.wei1;
  assign PECMAC_Wei2    = ops_q.wei2;

endmodule

// File: tb/tb_pec_row_seq.sv
// Directed bench for pec_row_seq with LENROW=4; a small MAC responder can answer each start pulse.
module tb_pec_row_seq;
  localparam int DW = 8;
  localparam int BD = 32;
  localparam int LR = 4;
  localparam int BW = DW*BD;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          row_sta = 1'b0, abort = 1'b0, buf_vld = 1'b0;
  logic          row_rdy, row_done, err, buf_rdy, sta, pls_acc, fnh_row;
  logic [BD-1:0] buf_flg_act = '0, buf_flg_w0 = '0, buf_flg_w1 = '0, buf_flg_w2 = '0;
  logic [BW-1:0] buf_act = '0, buf_w0 = '0, buf_w1 = '0, buf_w2 = '0;
  logic [BD-1:0] pec_flg_act, pec_flg_w0, pec_flg_w1, pec_flg_w2;
  logic [BW-1:0] pec_act, pec_w0, pec_w1, pec_w2;
  logic [1:0]    col;
  logic [2:0]    fnh_man = '0, fnh_auto = '0, fnh;
  logic          auto_mac = 1'b0, prev_sta = 1'b0;
  int            tests = 0, fails = 0;

  assign fnh = fnh_man | fnh_auto;

  pec_row_seq #(.DATA_WIDTH(DW), .BLOCK_DEPTH(BD), .LENROW(LR)) dut (
    .clk(clk), .rst_n(rst_n),
    .CTRL_RowSta(row_sta), .CTRL_Abort(abort), .CTRL_RowRdy(row_rdy),
    .CTRL_RowDone(row_done), .CTRL_Err(err),
    .BUF_Vld(buf_vld), .BUF_Rdy(buf_rdy),
    .BUF_FlgAct(buf_flg_act), .BUF_Act(buf_act),
    .BUF_FlgWei0(buf_flg_w0), .BUF_FlgWei1(buf_flg_w1), .BUF_FlgWei2(buf_flg_w2),
    .BUF_Wei0(buf_w0), .BUF_Wei1(buf_w1), .BUF_Wei2(buf_w2),
    .PECMAC_FlgAct(pec_flg_act), .PECMAC_Act(pec_act),
    .PECMAC_FlgWei0(pec_flg_w0), .PECMAC_FlgWei1(pec_flg_w1), .PECMAC_FlgWei2(pec_flg_w2),
    .PECMAC_Wei0(pec_w0), .PECMAC_Wei1(pec_w1), .PECMAC_Wei2(pec_w2),
    .PECMAC_Sta(sta),
    .MACPEC_Fnh0(fnh[0]), .MACPEC_Fnh1(fnh[1]), .MACPEC_Fnh2(fnh[2]),
    .PECCNV_PlsAcc(pls_acc), .PECCNV_FnhRow(fnh_row), .Col(col)
  );

  always #5 clk = ~clk;

  // All three MACs finish in the first WAIT cycle after a start pulse.
  always @(posedge clk) begin
    #1;
    fnh_auto = (auto_mac && prev_sta) ? 3'b111 : 3'b000;
    prev_sta = sta;
  end

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic start_row;
    row_sta = 1'b1;
    step();
    row_sta = 1'b0;
  endtask

  task automatic wait_sta(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 60 && !ok; i++) begin
      if (sta === 1'b1) ok = 1'b1;
      else step();
    end
  endtask

  task automatic wait_done(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 100 && !ok; i++) begin
      if (row_done === 1'b1) ok = 1'b1;
      else step();
    end
  endtask

  task automatic test_reset;
    logic [8:0] obs;
    #12;
    obs = {row_rdy, buf_rdy, sta, pls_acc, fnh_row, row_done, err, col};
    tests++;
    if (obs !== 9'b1_0000_0000) begin
      fails++; $display("FAIL reset_ctrl got=%b exp=%b", obs, 9'b1_0000_0000);
    end
    tests++;
    if ({pec_act, pec_w0, pec_flg_act} !== '0) begin
      fails++; $display("FAIL reset_operands got nonzero exp=0");
    end
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_row;
    int pa_cnt = 0, done_cyc = -1, overlap = 0;
    int pa_cyc[4];
    logic [1:0] pa_col[4];
    logic fnh_at_done = 1'b0;
    for (int i = 0; i < 4; i++) begin pa_cyc[i] = -1; pa_col[i] = 2'bxx; end
    buf_act = {BD{8'h3C}}; buf_w0 = {BD{8'h11}}; buf_vld = 1'b1; auto_mac = 1'b1;
    start_row();
    for (int c = 0; c < 40 && done_cyc < 0; c++) begin
      if (pls_acc === 1'b1) begin
        if (pa_cnt < 4) begin pa_cyc[pa_cnt] = c; pa_col[pa_cnt] = col; end
        pa_cnt++;
      end
      if ((sta + pls_acc + fnh_row) > 1) overlap++;
      if (row_done === 1'b1) begin done_cyc = c; fnh_at_done = fnh_row; end
      else step();
    end
    tests++;
    if (pa_cnt != 4) begin fails++; $display("FAIL row_placc_count got=%0d exp=4", pa_cnt); end
    tests++;
    if (pa_cyc[0] != 3) begin fails++; $display("FAIL row_first_placc got=%0d exp=3", pa_cyc[0]); end
    for (int i = 1; i < 4; i++) begin
      tests++;
      if (pa_cyc[i] - pa_cyc[i-1] != 4) begin
        fails++; $display("FAIL row_placc_gap%0d got=%0d exp=4", i, pa_cyc[i] - pa_cyc[i-1]);
      end
    end
    for (int i = 0; i < 4; i++) begin
      tests++;
      if (pa_col[i] !== 2'(i)) begin fails++; $display("FAIL row_col%0d got=%0d exp=%0d", i, pa_col[i], i); end
    end
    tests++;
    if (done_cyc + 1 != 17) begin fails++; $display("FAIL row_length got=%0d exp=17", done_cyc + 1); end
    tests++;
    if (done_cyc != pa_cyc[3] + 1) begin
      fails++; $display("FAIL row_done_after_placc got=%0d exp=%0d", done_cyc, pa_cyc[3] + 1);
    end
    tests++;
    if (fnh_at_done !== 1'b1) begin fails++; $display("FAIL row_fnhrow got=%b exp=1", fnh_at_done); end
    tests++;
    if (overlap != 0) begin fails++; $display("FAIL row_pulse_overlap got=%0d exp=0", overlap); end
    tests++;
    if (pec_act !== {BD{8'h3C}}) begin fails++; $display("FAIL row_act got=%h exp=3c..", pec_act[7:0]); end
    step();
    tests++;
    if ({row_rdy, row_done, col, err} !== 5'b10000) begin
      fails++; $display("FAIL row_idle got=%b exp=10000", {row_rdy, row_done, col, err});
    end
  endtask

  task automatic test_stagger;
    bit ok;
    auto_mac = 1'b0; buf_vld = 1'b1;
    start_row();
    wait_sta(ok);
    tests++;
    if (!ok) begin fails++; $display("FAIL stagger_sta_timeout got=0 exp=1"); end
    step();                          // WAIT+0
    fnh_man = 3'b001; step(); fnh_man = 3'b000;
    step(); step();                  // WAIT+3
    fnh_man = 3'b100; step(); fnh_man = 3'b000;
    step();                          // WAIT+5
    tests++;
    if (pls_acc !== 1'b0) begin fails++; $display("FAIL stagger_early_placc got=%b exp=0", pls_acc); end
    fnh_man = 3'b010; step(); fnh_man = 3'b000;
    tests++;
    if (pls_acc !== 1'b1) begin fails++; $display("FAIL stagger_placc got=%b exp=1", pls_acc); end
    tests++;
    if (err !== 1'b0) begin fails++; $display("FAIL stagger_err got=%b exp=0", err); end
    auto_mac = 1'b1;
    wait_done(ok);
    tests++;
    if (!ok) begin fails++; $display("FAIL stagger_done_timeout got=0 exp=1"); end
    step();
  endtask

  task automatic test_backpressure;
    bit ok;
    auto_mac = 1'b1; buf_vld = 1'b0;
    buf_act = {BD{8'hA5}}; buf_flg_act = 32'h1234_5678; buf_w1 = {BD{8'h77}};
    start_row();
    for (int i = 0; i < 7; i++) begin
      tests++;
      if (buf_rdy !== 1'b1 || pec_act !== {BD{8'h3C}}) begin
        fails++; $display("FAIL bp_hold%0d rdy=%b act=%h exp rdy=1 act=3c", i, buf_rdy, pec_act[7:0]);
      end
      step();
    end
    buf_vld = 1'b1;
    step();
    tests++;
    if (pec_act !== {BD{8'hA5}}) begin fails++; $display("FAIL bp_act got=%h exp=a5..", pec_act[15:0]); end
    tests++;
    if (pec_flg_act !== 32'h1234_5678 || pec_w1 !== {BD{8'h77}}) begin
      fails++; $display("FAIL bp_fields flg=%h w1=%h exp flg=12345678 w1=77..", pec_flg_act, pec_w1[7:0]);
    end
    tests++;
    if (sta !== 1'b1) begin fails++; $display("FAIL bp_sta got=%b exp=1", sta); end
    wait_done(ok);
    tests++;
    if (!ok) begin fails++; $display("FAIL bp_done_timeout got=0 exp=1"); end
    step();
  endtask

  task automatic test_abort;
    bit ok;
    int bad = 0;
    buf_act = {BD{8'hC3}}; buf_vld = 1'b1; auto_mac = 1'b1;
    start_row();
    for (int i = 0; i < 60 && col !== 2'd2; i++) step();
    tests++;
    if (col !== 2'd2) begin fails++; $display("FAIL abort_reach_col2 got=%0d exp=2", col); end
    auto_mac = 1'b0;
    wait_sta(ok);
    tests++;
    if (!ok) begin fails++; $display("FAIL abort_sta_timeout got=0 exp=1"); end
    step();                          // WAIT of column 2
    abort = 1'b1; step(); abort = 1'b0;
    tests++;
    if ({row_rdy, col, pls_acc, fnh_row, buf_rdy} !== 6'b100000) begin
      fails++; $display("FAIL abort_idle got=%b exp=100000", {row_rdy, col, pls_acc, fnh_row, buf_rdy});
    end
    for (int i = 0; i < 4; i++) begin
      if (pls_acc !== 1'b0 || fnh_row !== 1'b0 || row_rdy !== 1'b1) bad++;
      step();
    end
    tests++;
    if (bad != 0) begin fails++; $display("FAIL abort_quiet got=%0d exp=0", bad); end
    // Abort coinciding with the buffer handshake must not capture.
    buf_act = {BD{8'h5A}}; buf_vld = 1'b0;
    start_row();
    tests++;
    if (col !== 2'd0 || buf_rdy !== 1'b1) begin
      fails++; $display("FAIL abort_restart col=%0d rdy=%b exp col=0 rdy=1", col, buf_rdy);
    end
    buf_vld = 1'b1; abort = 1'b1; step(); abort = 1'b0;
    tests++;
    if (pec_act !== {BD{8'hC3}} || row_rdy !== 1'b1) begin
      fails++; $display("FAIL abort_no_capture act=%h rdy=%b exp act=c3 rdy=1", pec_act[7:0], row_rdy);
    end
    auto_mac = 1'b1;
    start_row();
    wait_done(ok);
    tests++;
    if (!ok || pec_act !== {BD{8'h5A}}) begin
      fails++; $display("FAIL abort_full_row ok=%b act=%h exp ok=1 act=5a", ok, pec_act[7:0]);
    end
    step();
  endtask

  task automatic test_err_spurious;
    auto_mac = 1'b0;
    tests++;
    if (err !== 1'b0) begin fails++; $display("FAIL err_pre got=%b exp=0", err); end
    fnh_man = 3'b010; step(); fnh_man = 3'b000;
    tests++;
    if (err !== 1'b1) begin fails++; $display("FAIL err_idle_fnh1 got=%b exp=1", err); end
    step(); step();
    tests++;
    if (err !== 1'b1 || row_rdy !== 1'b1) begin
      fails++; $display("FAIL err_sticky err=%b rdy=%b exp err=1 rdy=1", err, row_rdy);
    end
  endtask

  task automatic test_reset_midwait;
    auto_mac = 1'b0; buf_vld = 1'b0;
    start_row();
    row_sta = 1'b1; step(); row_sta = 1'b0;
    tests++;
    if ({buf_rdy, col, row_rdy} !== 4'b1000) begin
      fails++; $display("FAIL rs_ignored_fetch got=%b exp=1000", {buf_rdy, col, row_rdy});
    end
    buf_vld = 1'b1;
    step(); step();                  // START, then WAIT
    row_sta = 1'b1; step(); row_sta = 1'b0;
    tests++;
    if ({row_rdy, buf_rdy, sta, pls_acc} !== 4'b0000) begin
      fails++; $display("FAIL rs_ignored_wait got=%b exp=0000", {row_rdy, buf_rdy, sta, pls_acc});
    end
    #1 rst_n = 1'b0;
    #1;
    tests++;
    if ({row_rdy, buf_rdy, sta, pls_acc, fnh_row, row_done, err, col} !== 9'b1_0000_0000) begin
      fails++; $display("FAIL midreset_ctrl got=%b exp=100000000",
                        {row_rdy, buf_rdy, sta, pls_acc, fnh_row, row_done, err, col});
    end
    tests++;
    if ({pec_act, pec_w2, pec_flg_w0} !== '0) begin fails++; $display("FAIL midreset_operands got nonzero exp=0"); end
    #1 rst_n = 1'b1;
    step();
  endtask

  task automatic test_double_fnh;
    bit ok;
    auto_mac = 1'b0; buf_vld = 1'b1;
    start_row();
    wait_sta(ok);
    tests++;
    if (!ok) begin fails++; $display("FAIL dbl_sta_timeout got=0 exp=1"); end
    step();
    fnh_man = 3'b001; step(); fnh_man = 3'b000;
    tests++;
    if (err !== 1'b0) begin fails++; $display("FAIL dbl_first_fnh0 got=%b exp=0", err); end
    step();
    fnh_man = 3'b001; step(); fnh_man = 3'b000;
    tests++;
    if (err !== 1'b1) begin fails++; $display("FAIL dbl_second_fnh0 got=%b exp=1", err); end
    fnh_man = 3'b110; step(); fnh_man = 3'b000;
    tests++;
    if (pls_acc !== 1'b1) begin fails++; $display("FAIL dbl_placc got=%b exp=1", pls_acc); end
    auto_mac = 1'b1;
    wait_done(ok);
    tests++;
    if (!ok || err !== 1'b1) begin fails++; $display("FAIL dbl_row_done ok=%b err=%b exp ok=1 err=1", ok, err); end
    step();
  endtask

  initial begin
    test_reset();
    test_row();
    test_stagger();
    test_backpressure();
    test_abort();
    test_err_spurious();
    test_reset_midwait();
    test_double_fnh();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
